// File: rtl/if_agc_ctrl.sv
// IF-filter AGC: windowed peak detector that steps the filter gain select down on
// overload and up after sustained low level, with a manual pass-through mode.
module if_agc_ctrl #(
  parameter int WINDOW_LOG2  = 10,
  parameter int HOLD_WINDOWS = 4,
  parameter int HI_THRESH    = 96,
  parameter int LO_THRESH    = 24
) (
  input  logic              clk,
  input  logic              RSTb,
  input  logic signed [7:0] if_filt_out,
  input  logic              sample_en,
  input  logic              agc_en,
  input  logic [2:0]        manual_gain,
  output logic [2:0]        gain_sel,
  output logic [6:0]        peak_last,
  output logic              clip_flag,
  output logic              win_strobe,
  output logic [1:0]        agc_state
);

  typedef enum logic [1:0] {
    S_MEASURE = 2'd0,
    S_SETTLE  = 2'd1,
    S_MANUAL  = 2'd2
  } state_t;

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] WIN_ONE  = WINDOW_LOG2'(1);
  localparam logic [6:0]             HI_T     = 7'(HI_THRESH);
  localparam logic [6:0]             LO_T     = 7'(LO_THRESH);
  localparam logic [3:0]             HOLD_T   = 4'(HOLD_WINDOWS);
  localparam logic [2:0]             GAIN_MAX = 3'd5;

  state_t                 state, state_nxt;
  logic [WINDOW_LOG2-1:0] win_cnt;
  logic [6:0]             peak_run;
  logic                   clip_acc;
  logic [3:0]             hold_cnt;

  logic [7:0] neg_val;
  logic [6:0] mag;
  logic       is_clip;
  logic [6:0] final_peak;
  logic       final_clip;
  logic       win_end;
  logic [3:0] hold_inc;
  logic [2:0] dec_gain;
  logic [3:0] dec_hold;
  logic [2:0] manual_clamped;

  assign agc_state = state;

  // -128 has no 8-bit positive counterpart, so it saturates to full scale.
  always_comb begin
    neg_val = 8'd0 - if_filt_out;
    if (if_filt_out == 8'sh80) mag = 7'd127;
    else if (if_filt_out[7])   mag = neg_val[6:0];
    else                       mag = if_filt_out[6:0];
  end

  assign is_clip        = (mag == 7'd127);
  assign final_peak     = (mag > peak_run) ? mag : peak_run;
  assign final_clip     = clip_acc | is_clip;
  assign win_end        = sample_en && (win_cnt == WIN_LAST);
  assign hold_inc       = hold_cnt + 4'd1;
  assign manual_clamped = (manual_gain > GAIN_MAX) ? GAIN_MAX : manual_gain;

  // State register.
  always_ff @(posedge clk) begin
    if (!RSTb) state <= S_MEASURE;
    else       state <= state_nxt;
  end

  // Next-state logic: a gain change always buys one settle window.
  always_comb begin
    state_nxt = state;
    if (!agc_en) begin
      state_nxt = S_MANUAL;
    end else begin
      case (state)
        S_MANUAL:  state_nxt = S_MEASURE;
        S_MEASURE: if (win_end && (dec_gain != gain_sel)) state_nxt = S_SETTLE;
        S_SETTLE:  if (win_end) state_nxt = S_MEASURE;
        default:   state_nxt = S_MEASURE;
      endcase
    end
  end

  // Gain decision for the window that ends this cycle, by priority.
  always_comb begin
    dec_gain = gain_sel;
    dec_hold = 4'd0;
    if (final_clip) begin
      dec_gain = (gain_sel >= 3'd2) ? (gain_sel - 3'd2) : 3'd0;
    end else if (final_peak >= HI_T) begin
      dec_gain = (gain_sel != 3'd0) ? (gain_sel - 3'd1) : 3'd0;
    end else if (final_peak < LO_T) begin
      if (hold_inc >= HOLD_T) begin
        dec_gain = (gain_sel < GAIN_MAX) ? (gain_sel + 3'd1) : GAIN_MAX;
      end else begin
        dec_hold = hold_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTb) begin
      gain_sel   <= 3'd0;
      peak_last  <= 7'd0;
      clip_flag  <= 1'b0;
      win_strobe <= 1'b0;
      win_cnt    <= '0;
      peak_run   <= 7'd0;
      clip_acc   <= 1'b0;
      hold_cnt   <= 4'd0;
    end else begin
      win_strobe <= 1'b0;
      if (!agc_en) begin
        gain_sel <= manual_clamped;
        win_cnt  <= '0;
        peak_run <= 7'd0;
        clip_acc <= 1'b0;
        hold_cnt <= 4'd0;
      end else if ((state != S_MANUAL) && sample_en) begin
        if (win_end) begin
          peak_last  <= final_peak;
          clip_flag  <= final_clip;
          win_strobe <= 1'b1;
          win_cnt    <= '0;
          peak_run   <= 7'd0;
          clip_acc   <= 1'b0;
          if (state == S_MEASURE) begin
            gain_sel <= dec_gain;
            hold_cnt <= dec_hold;
          end else begin
            hold_cnt <= 4'd0;
          end
        end else begin
          win_cnt  <= win_cnt + WIN_ONE;
          peak_run <= final_peak;
          clip_acc <= final_clip;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_agc_ctrl.sv
// Directed bench for if_agc_ctrl with 16-sample windows and a 2-window hold;
// expected window peaks flow through a queue checked on every strobe.
module tb_if_agc_ctrl;

  logic              clk = 1'b0;
  logic              RSTb;
  logic signed [7:0] if_filt_out;
  logic              sample_en;
  logic              agc_en;
  logic [2:0]        manual_gain;
  logic [2:0]        gain_sel;
  logic [6:0]        peak_last;
  logic              clip_flag;
  logic              win_strobe;
  logic [1:0]        agc_state;

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_cnt = 0;
  logic [6:0] exp_q[$];

  if_agc_ctrl #(
    .WINDOW_LOG2(4), .HOLD_WINDOWS(2), .HI_THRESH(96), .LO_THRESH(24)
  ) dut (
    .clk(clk), .RSTb(RSTb), .if_filt_out(if_filt_out), .sample_en(sample_en),
    .agc_en(agc_en), .manual_gain(manual_gain), .gain_sel(gain_sel),
    .peak_last(peak_last), .clip_flag(clip_flag), .win_strobe(win_strobe),
    .agc_state(agc_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Scoreboard: every strobe must match the next expected window peak.
  always @(posedge clk) begin
    #1;
    if (win_strobe) begin
      strobe_cnt++;
      check("strobe_has_exp", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("peak_scoreboard", peak_last, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    if_filt_out = 8'(v);
    sample_en   = 1'b1;
    tick();
    sample_en   = 1'b0;
  endtask

  task automatic idle(input int v);
    if_filt_out = 8'(v);
    sample_en   = 1'b0;
    tick();
  endtask

  task automatic send_window(input int base, input int special, input int exp_peak);
    exp_q.push_back(7'(exp_peak));
    for (int i = 0; i < 16; i++) begin
      if (i == 7)          send(special);
      else if (i % 2 == 1) send(-base);
      else                 send(base);
    end
    check("strobe_at_window_end", win_strobe, 1);
  endtask

  initial begin
    int e;
    int s0;
    RSTb = 1'b0; agc_en = 1'b1; sample_en = 1'b0; if_filt_out = 8'sd0; manual_gain = 3'd0;
    repeat (3) tick();
    check("rst_gain", gain_sel, 0);
    check("rst_peak", peak_last, 0);
    check("rst_clip", clip_flag, 0);
    check("rst_strobe", win_strobe, 0);
    RSTb = 1'b1;
    idle(0);
    check("rst_state", agc_state, 0);

    // Ramp up on a constant +-10 signal: steps after windows 2,5,8,11,14.
    for (int k = 1; k <= 17; k++) begin
      send_window(10, 10, 10);
      e = (k + 1) / 3;
      if (e > 5) e = 5;
      check("ramp_gain", gain_sel, e);
      check("ramp_clip", clip_flag, 0);
      idle(0);
      check("ramp_strobe_one_cycle", win_strobe, 0);
    end

    // Clip drops gain by 2; the settle window ignores a high peak.
    send_window(40, -128, 127);
    check("clip_flag", clip_flag, 1);
    check("clip_gain", gain_sel, 3);
    check("clip_state_settle", agc_state, 1);
    send_window(40, 100, 100);
    check("settle_gain", gain_sel, 3);
    check("settle_clip", clip_flag, 0);
    check("settle_state", agc_state, 0);

    // Threshold edges and hold-counter clearing.
    send_window(40, 96, 96);
    check("hi_thresh_gain", gain_sel, 2);
    send_window(40, 50, 50);
    check("settle2_gain", gain_sel, 2);
    send_window(5, -23, 23);
    check("low1_gain", gain_sel, 2);
    send_window(5, -95, 95);
    check("below_hi_gain", gain_sel, 2);
    send_window(5, 23, 23);
    check("hold_cleared_by_95", gain_sel, 2);
    send_window(5, 24, 24);
    check("lo_thresh_not_low", gain_sel, 2);
    send_window(5, -23, 23);
    check("hold_cleared_by_24", gain_sel, 2);
    send_window(5, 23, 23);
    check("two_low_windows_inc", gain_sel, 3);
    check("inc_state_settle", agc_state, 1);

    // Partial window, then manual mode.
    for (int i = 0; i < 8; i++) send(80);
    agc_en = 1'b0; manual_gain = 3'd7;
    idle(0);
    check("manual_clamp", gain_sel, 5);
    check("manual_state", agc_state, 2);
    manual_gain = 3'd2;
    idle(0);
    check("manual_follow", gain_sel, 2);
    s0 = strobe_cnt;
    for (int i = 0; i < 20; i++) send(100);
    check("manual_no_strobe", strobe_cnt - s0, 0);
    manual_gain = 3'd4;
    idle(0);
    check("manual_gain4", gain_sel, 4);
    agc_en = 1'b1;
    idle(0);
    check("auto_reentry_state", agc_state, 0);
    check("auto_keeps_gain", gain_sel, 4);
    exp_q.push_back(7'd10);
    for (int i = 0; i < 15; i++) send((i % 2 == 0) ? 10 : -10);
    check("no_early_strobe", win_strobe, 0);
    send(10);
    check("fresh_window_strobe", win_strobe, 1);
    check("fresh_window_gain", gain_sel, 4);

    // Gapped sample_en: ignored values of 120 during gaps must not count.
    exp_q.push_back(7'd10);
    for (int i = 0; i < 16; i++) begin
      send((i % 2 == 0) ? 10 : -10);
      check("gap_strobe", win_strobe, 32'(i == 15));
      if (i != 15) begin
        idle(120);
        idle(-120);
        check("gap_hold_gain", gain_sel, 4);
        check("gap_hold_strobe", win_strobe, 0);
      end
    end
    check("gap_gain_inc", gain_sel, 5);

    // Reset in mid-window.
    for (int i = 0; i < 8; i++) send(-128);
    RSTb = 1'b0; sample_en = 1'b1;
    tick();
    RSTb = 1'b1; sample_en = 1'b0;
    check("midrst_gain", gain_sel, 0);
    check("midrst_peak", peak_last, 0);
    check("midrst_clip", clip_flag, 0);
    check("midrst_strobe", win_strobe, 0);
    check("midrst_state", agc_state, 0);
    send_window(10, 10, 10);
    check("post_rst_clip", clip_flag, 0);
    check("post_rst_gain", gain_sel, 0);

    idle(0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
